// File: rtl/uart_pkg.sv
// Shared types and constants for the Patmos console UART receiver.
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 694;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to
// the idle-high level so reset never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with a one-entry holding register and valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err pulse.
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx_i,
  output logic [UART_DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_err,
  output logic                   overrun,
`ifdef UART_RX_PARITY_EN
  output logic                   parity_err,
`endif
  output logic                   busy
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

  logic                   rx_s;
  uart_rx_state_t         state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             idx_q;
  logic [UART_DATA_W-1:0] shiftReg_q;
  logic [UART_DATA_W-1:0] holdData_q;
  logic                   holdValid_q;
  logic                   frameErr_q;
  logic                   overrun_q;
  logic [1:0]             settle_q;
  logic                   rxPrev_q;
  logic                   expire;
`ifdef UART_RX_PARITY_EN
  logic                   parityBad_q;
  logic                   parityErr_q;
`endif

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rx_i),
    .q_o     (rx_s)
  );

  assign expire = (cnt_q == CNT_W'(1));

  // rxPrev_q stays 0 until the synchronizer has flushed its reset value, so a
  // line that is already low at reset release cannot be mistaken for a start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shiftReg_q  <= '0;
      holdData_q  <= '0;
      holdValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
      settle_q    <= 2'b00;
      rxPrev_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      settle_q   <= {settle_q[0], 1'b1};
      rxPrev_q   <= settle_q[1] ? rx_s : 1'b0;
      frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErr_q <= 1'b0;
`endif
      if (holdValid_q && out_ready) holdValid_q <= 1'b0;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);

      case (state_q)
        IDLE: begin
          if (rxPrev_q && !rx_s) begin
            cnt_q   <= CNT_HALF;
            state_q <= START;
          end
        end
        START: begin
          if (expire) begin
            if (!rx_s) begin
              cnt_q   <= CNT_FULL;
              idx_q   <= '0;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (expire) begin
            shiftReg_q[idx_q] <= rx_s;
            cnt_q             <= CNT_FULL;
            idx_q             <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (expire) begin
            parityBad_q <= (^shiftReg_q) ^ rx_s;
            cnt_q       <= CNT_FULL;
            state_q     <= STOP;
          end
        end
`endif
        STOP: begin
          if (expire) begin
`ifdef UART_RX_PARITY_EN
            parityErr_q <= parityBad_q;
`endif
            if (rx_s) begin
              // A simultaneous handshake frees the slot, so only a stalled consumer overruns.
              holdData_q  <= shiftReg_q;
              holdValid_q <= 1'b1;
              if (holdValid_q && !out_ready) overrun_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = holdData_q;
  assign out_valid = holdValid_q;
  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parityErr_q;
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: a frame-level model predicts every
// output cycle by cycle; directed literal checks pin the model. Honours UART_RX_PARITY_EN.
module tb_uart_rx_monitor;
  import uart_pkg::*;

  localparam int CPB  = 694;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif
  // Edges from the one after which rx_i falls to the one that raises out_valid.
  localparam int LAT = 3 + HALF + (NBITS + 1) * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_i = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_monitor #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_i      (rx_i),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         good;
    logic [7:0] data;
    bit         perr;
  } ev_t;

  ev_t  evQ[$];
  int   cyc = 0;
  logic readyAtEdge = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic       mValid = 1'b0, mFerr = 1'b0, mOvr = 1'b0, mPerr = 1'b0, mBusy = 1'b0;
  logic [7:0] mData = 8'h00;
  int         mBusyFrom = 0, mBusyTo = 0;

  int         riseCount = 0, ferrCount = 0, perrCount = 0, riseCyc = 0;
  logic [7:0] riseData = 8'h00;
  logic       prevValid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edge counter and the out_ready value the DUT saw at that edge.
  always @(posedge clk) begin
    cyc++;
    readyAtEdge = out_ready;
  end

  // Frame-level model advanced once per cycle, then compared with the DUT.
  always @(negedge clk) begin
    ev_t ev;
    if (!reset_n) begin
      mValid = 1'b0; mData = 8'h00; mOvr = 1'b0; mFerr = 1'b0; mPerr = 1'b0;
      evQ.delete();
      mBusyFrom = 0; mBusyTo = 0;
    end else begin
      if (mValid && readyAtEdge) mValid = 1'b0;
      mFerr = 1'b0;
      mPerr = 1'b0;
      if (evQ.size() > 0 && evQ[0].cyc == cyc) begin
        ev = evQ.pop_front();
        if (ev.good) begin
          if (mValid) mOvr = 1'b1;
          mValid = 1'b1;
          mData  = ev.data;
        end else begin
          mFerr = 1'b1;
        end
        mPerr = ev.perr;
      end
    end
    mBusy = (cyc >= mBusyFrom) && (cyc < mBusyTo);
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    checkOutput("out_data", 32'(out_data), 32'(mData));
    checkOutput("frame_err", 32'(frame_err), 32'(mFerr));
    checkOutput("overrun", 32'(overrun), 32'(mOvr));
    checkOutput("busy", 32'(busy), 32'(mBusy));
`ifdef UART_RX_PARITY_EN
    checkOutput("parity_err", 32'(parity_err), 32'(mPerr));
`endif
  end

  // Pulse and rising-edge bookkeeping for the directed checks.
  always @(negedge clk) begin
    if (out_valid && !prevValid) begin
      riseCount++;
      riseCyc  = cyc;
      riseData = out_data;
    end
    prevValid = out_valid;
    if (frame_err) ferrCount++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perrCount++;
`endif
  end

  // Sends one frame starting just after the current edge and queues the model's
  // expectation. resetAtBit >= 0 pulses reset inside that data bit (line held).
  task automatic applyStimulus(input logic [7:0] data, input bit stopBit, input int stopLen,
                               input bit parityFlip, input int resetAtBit, output int startCyc);
    ev_t ev;
    int  k;
    k        = cyc;
    startCyc = k;
    ev.cyc   = k + LAT;
    ev.good  = stopBit;
    ev.data  = data;
`ifdef UART_RX_PARITY_EN
    ev.perr  = parityFlip;
`else
    ev.perr  = 1'b0;
`endif
    evQ.push_back(ev);
    mBusyFrom = k + 3;
    mBusyTo   = stopBit ? k + LAT : k + (1 + NBITS + stopLen) * CPB + 3;
    rx_i = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = data[i];
      if (i == resetAtBit) begin
        waitCycles(200);
        reset_n = 1'b0;
        waitCycles(300);
        reset_n = 1'b1;
        waitCycles(CPB - 500);
      end else begin
        waitCycles(CPB);
      end
    end
`ifdef UART_RX_PARITY_EN
    rx_i = (^data) ^ parityFlip;
    waitCycles(CPB);
`endif
    rx_i = stopBit;
    waitCycles(stopLen * CPB);
    rx_i = 1'b1;
  endtask

  initial begin
    int k;
    int r;
    int f;
    waitCycles(4);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'h00);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    waitCycles(20);

    // 0xAA with the consumer ready: one pulse, fixed latency.
    out_ready = 1'b1;
    applyStimulus(8'hAA, 1'b1, 1, 1'b0, -1, k);
    waitCycles(20);
    checkOutput("aa_rise_count", 32'(riseCount), 32'd1);
    checkOutput("aa_data", 32'(riseData), 32'hAA);
    checkOutput("aa_latency", 32'(riseCyc - k), (NBITS == 8) ? 32'd6596 : 32'd7290);
    checkOutput("aa_no_ferr", 32'(ferrCount), 32'd0);

    // 0x55 then 0x0F back-to-back with a stalled consumer.
    out_ready = 1'b0;
    applyStimulus(8'h55, 1'b1, 1, 1'b0, -1, k);
    applyStimulus(8'h0F, 1'b1, 1, 1'b0, -1, k);
    waitCycles(20);
    checkOutput("ovr_valid", 32'(out_valid), 32'd1);
    checkOutput("ovr_data", 32'(out_data), 32'h0F);
    checkOutput("ovr_flag", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    waitCycles(10);

    // 200-cycle low glitch on an idle line.
    r = riseCount;
    k = cyc;
    mBusyFrom = k + 3;
    mBusyTo   = k + 3 + HALF;
    rx_i = 1'b0;
    waitCycles(200);
    rx_i = 1'b1;
    waitCycles(400);
    checkOutput("glitch_no_byte", 32'(riseCount), 32'(r));
    checkOutput("glitch_no_ferr", 32'(ferrCount), 32'd0);

    // 0x00 with the stop bit held low for three bit times.
    applyStimulus(8'h00, 1'b0, 3, 1'b0, -1, k);
    checkOutput("ferr_busy_held", 32'(busy), 32'd1);
    waitCycles(20);
    checkOutput("ferr_pulses", 32'(ferrCount), 32'd1);
    checkOutput("ferr_no_byte", 32'(riseCount), 32'(r));
    checkOutput("ferr_ovr_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of 0xC3, then a clean 0x3C.
    f = ferrCount;
    applyStimulus(8'hC3, 1'b1, 1, 1'b0, 4, k);
    waitCycles(50);
    checkOutput("abort_no_byte", 32'(riseCount), 32'(r));
    checkOutput("abort_data", 32'(out_data), 32'h00);
    checkOutput("abort_overrun", 32'(overrun), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    applyStimulus(8'h3C, 1'b1, 1, 1'b0, -1, k);
    waitCycles(20);
    checkOutput("next_rise", 32'(riseCount), 32'(r + 1));
    checkOutput("next_data", 32'(riseData), 32'h3C);
    checkOutput("next_no_ferr", 32'(ferrCount), 32'(f));

`ifdef UART_RX_PARITY_EN
    // 0x01 with parity bit 0 (bad), then with parity bit 1 (good).
    applyStimulus(8'h01, 1'b1, 1, 1'b1, -1, k);
    waitCycles(20);
    checkOutput("par_bad_data", 32'(riseData), 32'h01);
    checkOutput("par_bad_pulse", 32'(perrCount), 32'd1);
    applyStimulus(8'h01, 1'b1, 1, 1'b0, -1, k);
    waitCycles(20);
    checkOutput("par_good_data", 32'(riseData), 32'h01);
    checkOutput("par_good_pulse", 32'(perrCount), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

Synthesizable 8-bit UART receiver for the Patmos simulation and FPGA harness. It deserialises the processor's `io_uartPins_tx` line into bytes, so a bench or board-side checker can consume console output over a valid/ready handshake. Frame format is 8N1, LSB first, line idle-high. The default bit period matches the 80 MHz / 115200 baud harness clocking.

## Interface
- `CLKS_PER_BIT`, 694, clock cycles per UART bit; must be ≥ 8.
- `clk` input 1: single clock domain, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `rx_i` input 1: serial line; asynchronous to `clk`; idle high.
- `out_data` output 8: received byte; stable while `out_valid`.
- `out_valid` output 1: byte available in the holding register.
- `out_ready` input 1: consumer accepts the byte when `out_valid && out_ready`.
- `frame_err` output 1: one-cycle pulse; stop bit sampled low.
- `overrun` output 1: sticky; a byte completed while the holding register was still full. Cleared only by reset.
- `busy` output 1: high in any state other than IDLE.

## Operation
- `rx_i` passes through a 2-flop synchronizer whose flops reset to 1. All logic below uses the synchronized value `rx_s`.
- States:
  - **IDLE**: waits for `rx_s` 1→0 (falling edge), then loads the baud counter with `CLKS_PER_BIT/2` (integer division) and enters START.
  - **START**: when the counter expires, samples `rx_s`. If it is 0, reload `CLKS_PER_BIT` and go to DATA. If it is 1 (glitch), return to IDLE with no output.
  - **DATA**: on each expiry, shift `rx_s` into bit `idx` (LSB first); `idx` counts 0..7. After bit 7, go to PARITY if enabled, otherwise STOP.
  - **PARITY**: see Configuration.
  - **STOP**: on expiry, sample `rx_s`.
    - If 1: transfer the shift register to the holding register.
    - If 0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - **WAIT_HIGH**: remain until `rx_s == 1`, then go to IDLE. This prevents a break condition being decoded as 0x00 streams.
- Holding register:
  - `out_valid` sets on transfer and clears on handshake.
  - If a transfer occurs while `out_valid && !out_ready`, the new byte overwrites the old one and `overrun` is set.
  - If the transfer coincides with a handshake in the same cycle, the new byte loads, `out_valid` stays 1, and there is no overrun.
- The baud counter is `$clog2(CLKS_PER_BIT+1)` bits wide. It decrements to 0, and "expiry" means the cycle in which it reads 1→0.

## Timing
- Reset values: `out_data`=0x00, `out_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, state=IDLE, synchronizer=1.
- A reset asserted mid-frame aborts the frame immediately. After reset release, the receiver does not arm until `rx_s` has been seen high for at least one cycle; IDLE edge detection provides this.
- Latency: `out_valid` rises 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles after the `rx_i` falling edge. Add `CLKS_PER_BIT` when parity is enabled.
- `frame_err` asserts in the cycle after the stop-bit sample and lasts exactly one cycle.
- Back-to-back frames: a new start edge is accepted from the first cycle after the stop sample (half-bit margin).
- `out_ready` has no combinational path to any output.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state samples a 9th bit after the data bits.
  - If the XOR of data bits and parity bit is not 0 (even parity), a `parity_err` output (1 bit, one-cycle pulse, reset 0) asserts alongside the stop-bit handling.
  - The byte is still delivered.
- Not defined: no PARITY state and no `parity_err` port. The frame is strictly 8N1.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - `UART_DATA_W = 8`;
  - default `CLKS_PER_BIT = 694`.
- One sub-module, `uart_sync2`, holds the reset-to-1 two-flop synchronizer. The FSM, counters and holding register stay in `uart_rx_monitor`.

## Test plan
- Drive `rx_i` with the 10-bit frame 0,0,1,0,1,0,1,0,1,1 (start, data LSB first, stop) at 694 clks/bit, with `out_ready`=1 → one `out_valid` pulse with `out_data`=0xAA, no `frame_err`.
- Send 0x55 then 0x0F back-to-back with `out_ready`=0 → `out_valid` stays 1, `out_data`=0x0F, `overrun`=1 and stays set.
- Send a 200-cycle low glitch on an idle line → returns to IDLE with no `out_valid` and no `frame_err`.
- Send a frame with data 0x00 and a low stop bit held low for 3 bit times → single `frame_err` pulse, no byte delivered, `busy` stays high until the line returns high.
- Assert `reset_n`=0 at data bit 4 of a 0xC3 frame, then release while the line is still low → all outputs 0; the remainder of that frame produces no byte; the next full 0x3C frame yields `out_data`=0x3C.
- With `UART_RX_PARITY_EN`, send 0x01 with parity bit 0 → `out_data`=0x01 and a one-cycle `parity_err` pulse. Send 0x01 with parity bit 1 → no `parity_err`.
